// File: rtl/comp2_slice_sequencer_pkg.sv
// Shared types and constants for the two's-complement slice sequencer.
// Holds the default widths, the state encoding and the requester ids.
package comp2_slice_sequencer_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SLICE_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam logic ID_MUL = 1'b0;
  localparam logic ID_DIV = 1'b1;

endpackage

// File: rtl/comp2_slice.sv
// Combinational SLICE-bit two's-complement cell chain.
// With cmp=1 it adds cin to the inverted operand; with cmp=0 it passes the operand through.
module comp2_slice
  import comp2_slice_sequencer_pkg::*;
#(
  parameter int SLICE = SLICE_DEF
) (
  input  logic [SLICE-1:0] a,
  input  logic             cin,
  input  logic             cmp,
  output logic [SLICE-1:0] r,
  output logic             cout
);

  logic [SLICE:0]   c;
  logic [SLICE-1:0] x;

  always_comb begin
    c    = '0;
    x    = '0;
    r    = '0;
    // Carry-in is forced to zero for pass-through so a stale carry cannot leak in.
    c[0] = cin & cmp;
    for (int i = 0; i < SLICE; i++) begin
      x[i]   = a[i] ^ cmp;
      r[i]   = x[i] ^ c[i];
      c[i+1] = x[i] & c[i];
    end
    cout = c[SLICE];
  end

endmodule

// File: rtl/comp2_slice_sequencer.sv
// Shares one comp2_slice between two requesters: round-robin accept, then
// WIDTH/SLICE serial passes LSB first, result held on a valid/ready port.
module comp2_slice_sequencer
  import comp2_slice_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic             req0_cmp,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic             req1_cmp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic             out_id,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NPASS = WIDTH / SLICE;
  localparam int KW    = (NPASS > 1) ? $clog2(NPASS) : 1;

  seq_state_t       state, state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] r_q;
  logic             cmp_q;
  logic             id_q;
  logic             carry_q;
  logic             last_grant_q;
  logic [KW-1:0]    k_q;

  logic             grant;
  logic             accept;
  logic             last_pass;
  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_r;
  logic             slice_cout;

  // Round-robin: a lone requester always wins; on contention the one not served last wins.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
  end

  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  assign last_pass = (k_q == KW'(NPASS - 1));
  assign slice_a   = a_q[k_q*SLICE +: SLICE];

  comp2_slice #(.SLICE(SLICE)) u_slice (
    .a    (slice_a),
    .cin  (carry_q),
    .cmp  (cmp_q),
    .r    (slice_r),
    .cout (slice_cout)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_pass) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      r_q          <= '0;
      cmp_q        <= 1'b0;
      id_q         <= ID_MUL;
      carry_q      <= 1'b0;
      k_q          <= '0;
      last_grant_q <= ID_DIV;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q          <= grant ? req1_a : req0_a;
            cmp_q        <= grant ? req1_cmp : req0_cmp;
            carry_q      <= grant ? req1_cmp : req0_cmp;
            id_q         <= grant;
            last_grant_q <= grant;
            k_q          <= '0;
          end
        end
        RUN: begin
          r_q[k_q*SLICE +: SLICE] <= slice_r;
          carry_q                 <= slice_cout;
          k_q                     <= k_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state == DONE);
  assign out_r     = r_q;
  assign out_id    = id_q;
  // Only -MIN overflows: the operand and its negation both carry the sign bit.
  assign out_ovf   = cmp_q & a_q[WIDTH-1] & r_q[WIDTH-1];
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_comp2_slice_sequencer.sv
// Self-checking bench: a job-level reference model compared every cycle,
// plus directed jobs with hand-computed literal results.
module tb_comp2_slice_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_cmp;
  logic [31:0] req0_a;
  logic        req1_valid, req1_ready, req1_cmp;
  logic [31:0] req1_a;
  logic        out_valid, out_ready, out_id, out_ovf, busy;
  logic [31:0] out_r;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  comp2_slice_sequencer dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_cmp(req0_cmp),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_cmp(req1_cmp),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_id(out_id),
    .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic cmp);
    return cmp ? (32'd0 - a) : a;
  endfunction

  function automatic logic ref_ovf(input logic [31:0] a, input logic cmp);
    return cmp && (a == 32'h8000_0000);
  endfunction

  // Job-level model: phase 0 = waiting for a job, 1..4 = slice passes, 5 = result held.
  int          m_phase = 0;
  logic        m_last  = 1'b1;
  logic [31:0] m_a     = '0;
  logic        m_cmp   = 1'b0;
  logic        m_id    = 1'b0;

  function automatic logic m_winner();
    if (req0_valid && req1_valid) return !m_last;
    return req1_valid;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_last  = 1'b1;
    end else if (m_phase == 0) begin
      if (req0_valid || req1_valid) begin
        m_id    = m_winner();
        m_a     = m_id ? req1_a : req0_a;
        m_cmp   = m_id ? req1_cmp : req0_cmp;
        m_last  = m_id;
        m_phase = 1;
      end
    end else if (m_phase < 5) begin
      m_phase = m_phase + 1;
    end else if (out_ready) begin
      m_phase = 0;
    end
  end

  logic e_acc, e_win;
  always @(negedge clk) begin
    if (cmp_en) begin
      e_acc = (m_phase == 0) && (req0_valid || req1_valid);
      e_win = m_winner();
      check("model_req0_ready", req0_ready, e_acc && !e_win);
      check("model_req1_ready", req1_ready, e_acc && e_win);
      check("model_busy", busy, m_phase != 0);
      check("model_out_valid", out_valid, m_phase == 5);
      if (m_phase == 5) begin
        check("model_out_r", out_r, ref_result(m_a, m_cmp));
        check("model_out_id", out_id, m_id);
        check("model_out_ovf", out_ovf, ref_ovf(m_a, m_cmp));
      end
    end
  end

  task automatic set_req(input int id, input logic v, input logic [31:0] a, input logic cmp);
    if (id == 0) begin req0_valid = v; req0_a = a; req0_cmp = cmp; end
    else         begin req1_valid = v; req1_a = a; req1_cmp = cmp; end
  endtask

  // Called at posedge+1; returns at posedge+1 with the DUT back in IDLE.
  task automatic run_job(input int id, input logic [31:0] a, input logic cmp,
                         input logic [31:0] exp_r, input logic exp_ovf,
                         input int hold, input bit pulse_other);
    int n;
    int lat;
    set_req(id, 1'b1, a, cmp);
    n = 0;
    @(negedge clk);
    while (!(id == 0 ? req0_ready : req1_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", n < 20, 1);
    @(posedge clk); #1;
    set_req(id, 1'b0, 32'h5A5A_5A5A, !cmp);
    if (pulse_other) begin
      set_req(1 - id, 1'b1, 32'hDEAD_BEEF, 1'b1);
      @(negedge clk);
      check("no_accept_in_run", id == 0 ? req1_ready : req0_ready, 0);
      @(posedge clk); #1;
      set_req(1 - id, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      lat = 2;
    end else begin
      @(negedge clk);
      lat = 1;
    end
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 5);
    check("out_r", out_r, exp_r);
    check("out_id", out_id, id);
    check("out_ovf", out_ovf, exp_ovf);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      set_req(0, 1'b1, 32'h1111_0000 + i, 1'b1);
      set_req(1, 1'b1, 32'h2222_0000 + i, 1'b0);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_r", out_r, exp_r);
      check("hold_id", out_id, id);
      check("hold_ready0", req0_ready, 0);
      check("hold_ready1", req1_ready, 0);
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h0, 1'b0);
    set_req(1, 1'b0, 32'h0, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic        ids[$];
  logic [31:0] vals[$];

  initial begin
    int n;
    rst = 1'b1;
    out_ready = 1'b0;
    set_req(0, 1'b0, 32'h0, 1'b0);
    set_req(1, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_id", out_id, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_busy", busy, 0);

    // Contention straight out of reset: requester 0 first, then alternate.
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'h0000_0010, 1'b1);
    set_req(1, 1'b1, 32'h0000_0020, 1'b0);
    out_ready = 1'b1;
    n = 0;
    while (ids.size() < 4 && n < 60) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        ids.push_back(out_id);
        vals.push_back(out_r);
      end
      n++;
    end
    check("rr_wait", n < 60, 1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h0, 1'b0);
    set_req(1, 1'b0, 32'h0, 1'b0);
    out_ready = 1'b0;
    if (ids.size() == 4) begin
      check("rr_id0", ids[0], 0);
      check("rr_id1", ids[1], 1);
      check("rr_id2", ids[2], 0);
      check("rr_id3", ids[3], 1);
      check("rr_val0", vals[0], 32'hFFFF_FFF0);
      check("rr_val1", vals[1], 32'h0000_0020);
    end

    run_job(0, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    run_job(1, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1, 0, 1'b0);
    run_job(1, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 0, 1'b0);
    run_job(0, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 0, 1'b0);
    run_job(0, 32'h1234_5678, 1'b1, 32'hEDCB_A988, 1'b0, 0, 1'b1);
    run_job(1, 32'h0000_00FF, 1'b1, 32'hFFFF_FF01, 1'b0, 10, 1'b0);
    run_job(1, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 0, 1'b1);

    // Reset during the second slice pass drops the job; requester 0 re-presents.
    set_req(0, 1'b1, 32'h0000_0100, 1'b1);
    n = 0;
    @(negedge clk);
    while (!req0_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_job_accept", n < 20, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_busy", busy, 0);
    check("after_rst_out_valid", out_valid, 0);
    check("after_rst_reaccept", req0_ready, 1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rerun_wait", n < 20, 1);
    check("rerun_out_r", out_r, 32'hFFFF_FF00);
    check("rerun_out_id", out_id, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
